bp_update_queue: RTL and testbench

- Buffers resolved conditional-branch outcomes from the commit stage and drains them to the 2-bit counter-table predictor in fetch, one per cycle, on updatePC_i/updateDir_i/updateEn_i.
- Accepts up to two committed branches per cycle, in program order.
- Throttles commit with a stall signal when it is nearly full.
- Decouples commit bursts from the predictor's single read-modify-write update port.

---
 rtl/bp_update_queue.sv | 97 +++++++++
 tb/tb_bp_update_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue.sv
// rtl/bp_update_queue.sv - commit-to-predictor branch outcome update queue
module bp_update_queue #(
    parameter int SIZE_PC   = 32,
    parameter int DEPTH     = 8,
    parameter int DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 commitValid0_i,
    input  logic [SIZE_PC-1:0]   commitPC0_i,
    input  logic                 commitDir0_i,
    input  logic                 commitValid1_i,
    input  logic [SIZE_PC-1:0]   commitPC1_i,
    input  logic                 commitDir1_i,
    output logic                 stallCommit_o,
    output logic                 updateEn_o,
    output logic [SIZE_PC-1:0]   updatePC_o,
    output logic                 updateDir_o,
    output logic [DEPTH_LOG:0]   count_o,
    output logic                 overflow_o
);

    localparam logic [DEPTH_LOG:0] DEPTH_C      = DEPTH[DEPTH_LOG:0];
    localparam logic [DEPTH_LOG:0] DEPTH_M1_C   = DEPTH_C - 1'b1;

    logic [SIZE_PC-1:0]   pc_mem  [DEPTH];
    logic                 dir_mem [DEPTH];

    logic [DEPTH_LOG-1:0] head_ptr;
    logic [DEPTH_LOG-1:0] tail_ptr;
    logic [DEPTH_LOG-1:0] tail_ptr_p1;
    logic [DEPTH_LOG:0]   count;

    logic                 deq;
    logic [1:0]           n_valid;
    logic [DEPTH_LOG:0]   n_valid_w;
    logic [DEPTH_LOG:0]   free;
    logic [DEPTH_LOG:0]   n_enq;
    logic                 wr_a;
    logic                 wr_b;
    logic [SIZE_PC-1:0]   wr_a_pc;
    logic                 wr_a_dir;
    logic                 drop;

    // Free space is taken from the pre-dequeue count, so a full queue drops
    // everything even though one entry leaves this cycle.
    always_comb begin
        deq         = (count != '0);
        n_valid     = {1'b0, commitValid0_i} + {1'b0, commitValid1_i};
        n_valid_w   = {{(DEPTH_LOG-1){1'b0}}, n_valid};
        free        = DEPTH_C - count;
        n_enq       = (n_valid_w > free) ? free : n_valid_w;
        drop        = (n_valid_w > free);
        wr_a        = (n_enq != '0);
        wr_b        = (n_enq == {{(DEPTH_LOG-1){1'b0}}, 2'd2});
        wr_a_pc     = commitValid0_i ? commitPC0_i  : commitPC1_i;
        wr_a_dir    = commitValid0_i ? commitDir0_i : commitDir1_i;
        tail_ptr_p1 = tail_ptr + {{(DEPTH_LOG-1){1'b0}}, 1'b1};
    end

    // Second write only happens when both slots are valid, so it is always slot 1.
    always_ff @(posedge clk) begin
        if (wr_a) begin
            pc_mem[tail_ptr]  <= wr_a_pc;
            dir_mem[tail_ptr] <= wr_a_dir;
        end
        if (wr_b) begin
            pc_mem[tail_ptr_p1]  <= commitPC1_i;
            dir_mem[tail_ptr_p1] <= commitDir1_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (deq) begin
                head_ptr <= head_ptr + {{(DEPTH_LOG-1){1'b0}}, 1'b1};
            end
            tail_ptr <= tail_ptr + n_enq[DEPTH_LOG-1:0];
            count    <= count + n_enq - {{DEPTH_LOG{1'b0}}, deq};
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign updateEn_o    = deq;
    assign updatePC_o    = pc_mem[head_ptr];
    assign updateDir_o   = dir_mem[head_ptr];
    assign count_o       = count;
    assign stallCommit_o = (count >= DEPTH_M1_C);

endmodule

// File: tb/tb_bp_update_queue.sv
// tb/tb_bp_update_queue.sv - randomized and directed bench for bp_update_queue
module tb_bp_update_queue;

    localparam int SIZE_PC   = 32;
    localparam int DEPTH     = 8;
    localparam int DEPTH_LOG = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               commitValid0_i = 1'b0;
    logic [SIZE_PC-1:0] commitPC0_i = '0;
    logic               commitDir0_i = 1'b0;
    logic               commitValid1_i = 1'b0;
    logic [SIZE_PC-1:0] commitPC1_i = '0;
    logic               commitDir1_i = 1'b0;
    logic               stallCommit_o;
    logic               updateEn_o;
    logic [SIZE_PC-1:0] updatePC_o;
    logic               updateDir_o;
    logic [DEPTH_LOG:0] count_o;
    logic               overflow_o;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    logic [SIZE_PC:0] mq[$];
    bit               movf = 1'b0;
    int               m_free;
    int               m_n;

    bp_update_queue #(.SIZE_PC(SIZE_PC), .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG)) dut (
        .clk(clk), .reset(reset),
        .commitValid0_i(commitValid0_i), .commitPC0_i(commitPC0_i), .commitDir0_i(commitDir0_i),
        .commitValid1_i(commitValid1_i), .commitPC1_i(commitPC1_i), .commitDir1_i(commitDir1_i),
        .stallCommit_o(stallCommit_o), .updateEn_o(updateEn_o), .updatePC_o(updatePC_o),
        .updateDir_o(updateDir_o), .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of {pc,dir}; head leaves each clock, then valid slots
    // are appended in order while room (measured before the pop) remains.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            m_free = DEPTH - mq.size();
            m_n = 0;
            if (mq.size() != 0) void'(mq.pop_front());
            if (commitValid0_i) begin
                if (m_n < m_free) begin mq.push_back({commitPC0_i, commitDir0_i}); m_n++; end
                else movf = 1'b1;
            end
            if (commitValid1_i) begin
                if (m_n < m_free) begin mq.push_back({commitPC1_i, commitDir1_i}); m_n++; end
                else movf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on && !reset) begin
            chk("upd_en", 64'(updateEn_o), 64'(mq.size() != 0));
            chk("count", 64'(count_o), 64'(mq.size()));
            chk("stall", 64'(stallCommit_o), 64'(mq.size() >= DEPTH - 1));
            chk("overflow", 64'(overflow_o), 64'(movf));
            if (mq.size() != 0) begin
                chk("upd_pc", 64'(updatePC_o), 64'(mq[0][SIZE_PC:1]));
                chk("upd_dir", 64'(updateDir_o), 64'(mq[0][0]));
            end
        end
    end

    task automatic cyc(input bit v0, input logic [SIZE_PC-1:0] p0, input bit d0,
                       input bit v1, input logic [SIZE_PC-1:0] p1, input bit d1);
        commitValid0_i = v0; commitPC0_i = p0; commitDir0_i = d0;
        commitValid1_i = v1; commitPC1_i = p1; commitDir1_i = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, '0, 0);
    endtask

    logic [SIZE_PC-1:0] pc_a;
    logic [SIZE_PC-1:0] pc_b;
    bit                 va;
    bit                 vb;
    int                 seq;

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        cmp_on = 1'b1;

        // 1: idle after reset
        idle(5);
        #2;
        chk("t1_en", 64'(updateEn_o), 64'd0);
        chk("t1_count", 64'(count_o), 64'd0);
        chk("t1_stall", 64'(stallCommit_o), 64'd0);
        chk("t1_ovf", 64'(overflow_o), 64'd0);

        // 2: single enqueue, visible only after the write edge
        cyc(1, 32'h1000, 1, 0, '0, 0);
        #2;
        chk("t2_en", 64'(updateEn_o), 64'd1);
        chk("t2_pc", 64'(updatePC_o), 64'h1000);
        chk("t2_dir", 64'(updateDir_o), 64'd1);
        chk("t2_count", 64'(count_o), 64'd1);
        idle(1);
        #2;
        chk("t2_en_after", 64'(updateEn_o), 64'd0);
        chk("t2_count_after", 64'(count_o), 64'd0);

        // 3: burst of 8 PCs, two per cycle, honouring stall
        for (int i = 0; i < 4; i++) begin
            if (mq.size() < DEPTH - 1)
                cyc(1, 32'h2000 + 32'(8 * i), 0, 1, 32'h2004 + 32'(8 * i), 1);
            else
                cyc(0, '0, 0, 0, '0, 0);
        end
        #2;
        chk("t3_count", 64'(count_o), 64'd5);
        chk("t3_head", 64'(updatePC_o), 64'h200C);
        for (int i = 0; i < 5; i++) begin
            chk("t3_drain", 64'(updatePC_o), 64'(32'h200C + 32'(4 * i)));
            idle(1);
            #2;
        end
        chk("t3_ovf", 64'(overflow_o), 64'd0);

        // 4: only slot 1 valid
        cyc(0, 32'hDEAD, 1, 1, 32'h3000, 0);
        #2;
        chk("t4_pc", 64'(updatePC_o), 64'h3000);
        chk("t4_dir", 64'(updateDir_o), 64'd0);
        idle(2);

        // 5: streaming for several wraps, then random traffic honouring stall
        for (int i = 0; i < 3 * DEPTH; i++) cyc(1, 32'h4000 + 32'(4 * i), i[0], 0, '0, 0);
        seq = 0;
        for (int i = 0; i < 300; i++) begin
            va = ($urandom_range(0, 3) != 0);
            vb = ($urandom_range(0, 1) != 0);
            pc_a = 32'h8000_0000 + 32'(seq * 4);
            pc_b = pc_a + 32'd4;
            seq = seq + 2;
            if (mq.size() >= DEPTH - 1) begin va = 0; vb = 0; end
            cyc(va, pc_a, $urandom_range(0, 1) != 0, vb, pc_b, $urandom_range(0, 1) != 0);
        end
        chk("t5_ovf", 64'(overflow_o), 64'd0);
        idle(DEPTH + 1);

        // 6: ignore stall to overflow, then reset mid-drain
        for (int i = 0; i < 6; i++) cyc(1, 32'h5000 + 32'(8 * i), 1, 1, 32'h5004 + 32'(8 * i), 0);
        #2;
        chk("t6_count_full", 64'(count_o), 64'd7);
        chk("t6_ovf_pre", 64'(overflow_o), 64'd0);
        cyc(1, 32'h6000, 1, 1, 32'h6004, 1);
        #2;
        chk("t6_ovf", 64'(overflow_o), 64'd1);
        chk("t6_count", 64'(count_o), 64'd7);
        idle(3);
        #2;
        chk("t6_ovf_sticky", 64'(overflow_o), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_en", 64'(updateEn_o), 64'd0);
        chk("t6_rst_count", 64'(count_o), 64'd0);
        chk("t6_rst_ovf", 64'(overflow_o), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1, 32'h7000, 1, 0, '0, 0);
        #2;
        chk("t6_post_pc", 64'(updatePC_o), 64'h7000);
        chk("t6_post_count", 64'(count_o), 64'd1);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
